// File: rtl/periph_bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
// Includes the FSM state enum, the default region placement and the word-index width.
package periph_bridge_pkg;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0400_0000;
  localparam int          DEF_REGION_BITS = 24;

  // The peripheral block uses the same word-index width.
  localparam int          WORD_IDX_W      = DEF_REGION_BITS - 2;

  localparam logic [3:0]  BE_FULL         = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // True when the address falls outside the region, or no byte lane is enabled.
  function automatic logic req_is_err(input logic [31:0] addr,
                                      input logic [3:0]  be,
                                      input logic [31:0] base,
                                      input int          region_bits);
    return ((addr >> region_bits) != (base >> region_bits)) || (be == 4'h0);
  endfunction

endpackage

// File: rtl/periph_bridge_if.sv
// Bus bundle between the CPU load/store port, the bridge and the peripheral register block.
// master = CPU plus peripheral environment; slave = the bridge.
interface periph_bridge_if;

  // cpu_req is held high with stable fields until cpu_ack pulses for one cycle.
  // cpu_rdata/cpu_err are meaningful only during that pulse.
  // p_wr is a single-cycle full-word write strobe.
  // p_rdata answers p_addr combinationally.
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;

  logic [31:0] p_addr;
  logic        p_wr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_be, cpu_wdata, p_rdata,
    input  cpu_ack, cpu_rdata, cpu_err, p_addr, p_wr, p_wdata
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_be, cpu_wdata, p_rdata,
    output cpu_ack, cpu_rdata, cpu_err, p_addr, p_wr, p_wdata
  );

endinterface

// File: rtl/periph_bridge_byte_merge.sv
// Combinational byte-lane merge for read-modify-write.
// Each enabled lane takes the new word; every other lane keeps the old word.
module byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign merged_o[8*n +: 8] = be_i[n] ? new_i[8*n +: 8] : old_i[8*n +: 8];
  end

endmodule

// File: rtl/periph_bridge.sv
// Bridge from the byte-addressed CPU port to word-only peripheral registers, with RMW for partial stores.
// Optional PERIPH_BRIDGE_ERR_EN: out-of-region or empty-byte-enable requests are acknowledged with cpu_err=1.
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          REGION_BITS = DEF_REGION_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  periph_bridge_if.slave        bus,
  output state_e                state_o
);

`ifdef PERIPH_BRIDGE_ERR_EN
  localparam logic ERR_FLAG = 1'b1;
`else
  localparam logic ERR_FLAG = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p_addr_q, p_addr_d;
  logic        p_wr_q, p_wr_d;
  logic [31:0] p_wdata_q, p_wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_err;
  logic [31:0] word_idx;
  logic [31:0] merged;

  assign req_err  = req_is_err(bus.cpu_addr, bus.cpu_be, BASE_ADDR, REGION_BITS);
  assign word_idx = 32'(bus.cpu_addr[REGION_BITS-1:2]);

  byte_merge u_merge (
    .old_i    (bus.p_rdata),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  // Output registers are loaded on the transition into the state that shows them,
  // so p_wr and cpu_ack are asserted exactly while the FSM is in WR/RMW_WR and RESP.
  always_comb begin
    state_d   = state_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    p_addr_d  = p_addr_q;
    p_wr_d    = 1'b0;
    p_wdata_d = p_wdata_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          be_d    = bus.cpu_be;
          wdata_d = bus.cpu_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_err) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            err_d   = ERR_FLAG;
          end else begin
            p_addr_d = word_idx;
            if (!bus.cpu_wr) begin
              state_d = ST_RD;
            end else if (bus.cpu_be == BE_FULL) begin
              state_d   = ST_WR;
              p_wr_d    = 1'b1;
              p_wdata_d = bus.cpu_wdata;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD: begin
        rdata_d = bus.p_rdata;
        state_d = ST_RESP;
        ack_d   = 1'b1;
      end
      ST_WR: begin
        state_d = ST_RESP;
        ack_d   = 1'b1;
      end
      ST_RMW_RD: begin
        // Captured read and merge happen together; the write follows with no gap.
        p_wdata_d = merged;
        p_wr_d    = 1'b1;
        state_d   = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_RESP;
        ack_d   = 1'b1;
      end
      ST_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      be_q      <= '0;
      wdata_q   <= '0;
      p_addr_q  <= '0;
      p_wr_q    <= 1'b0;
      p_wdata_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      p_addr_q  <= p_addr_d;
      p_wr_q    <= p_wr_d;
      p_wdata_q <= p_wdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.p_addr    = p_addr_q;
  assign bus.p_wr      = p_wr_q;
  assign bus.p_wdata   = p_wdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge: directed cases plus randomized traffic against a transaction-level model.
// Builds with or without PERIPH_BRIDGE_ERR_EN.
module tb_periph_bridge;
  import periph_bridge_pkg::*;

`ifdef PERIPH_BRIDGE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam int W = 99;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  periph_bridge_if bus ();

  periph_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int ack_cnt  = 0;
  int pwr_cnt  = 0;
  int last_ack_cyc = 0;
  int last_pwr_cyc = 0;
  logic [31:0] seen_rdata  = '0;
  logic [31:0] seen_pwdata = '0;
  logic [31:0] seen_paddr  = '0;
  logic        seen_err    = 1'b0;
  bit          chk_en      = 1'b0;

  // Per-cycle expectation: {ack, err, p_wr, rdata, p_addr, p_wdata}
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic ack, input logic err, input logic pwr,
                                      input logic [31:0] rdata, input logic [31:0] paddr,
                                      input logic [31:0] pwdata);
    return {ack, err, pwr, rdata, paddr, pwdata};
  endfunction

  function automatic logic [31:0] hash(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // ---------------- peripheral register block (environment) ----------------
  logic [31:0] env_mem [16];

  always_comb bus.p_rdata = (bus.p_addr < 32'd16) ? env_mem[bus.p_addr[3:0]] : hash(bus.p_addr);

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
    end else if (bus.p_wr && bus.p_addr < 32'd16) begin
      env_mem[bus.p_addr[3:0]] <= bus.p_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] model_mem [16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] idx);
    return (idx < 32'd16) ? model_mem[idx[3:0]] : hash(idx);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; cycle 0 is the following rising edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input bit b2b, input bit keep);
    int          n;
    logic        err;
    logic [31:0] idx, mask, mrg;
    n   = 0;
    err = (addr[31:24] != 8'h04) || (be == 4'h0);
    idx = {10'd0, addr[23:2]};
    if (b2b) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      n++;
    end
    t0 = cyc + n;
    if (err) begin
      exp_q.push_back(mk(1, ERR_EXP, 0, 0, 0, 0));
      n += 1;
    end else if (!wr) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, model_read(idx), 0, 0));
      n += 2;
    end else if (be == 4'hF) begin
      exp_q.push_back(mk(0, 0, 1, 0, idx, wdata));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
      if (idx < 32'd16) model_mem[idx[3:0]] = wdata;
      n += 2;
    end else begin
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      mrg  = (wdata & mask) | (model_read(idx) & ~mask);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 1, 0, idx, mrg));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
      if (idx < 32'd16) model_mem[idx[3:0]] = mrg;
      n += 3;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_be    = be;
    bus.cpu_wdata = wdata;
    repeat (n) @(negedge clk);
    if (!keep) begin
      bus.cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #3;
    cyc++;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("cpu_ack", 32'(bus.cpu_ack), 32'(e[98]));
      check("p_wr", 32'(bus.p_wr), 32'(e[96]));
      if (e[98]) begin
        check("cpu_err", 32'(bus.cpu_err), 32'(e[97]));
        check("cpu_rdata", bus.cpu_rdata, e[95:64]);
      end
      if (e[96]) begin
        check("p_addr", bus.p_addr, e[63:32]);
        check("p_wdata", bus.p_wdata, e[31:0]);
      end
    end
    if (bus.cpu_ack) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      seen_rdata   = bus.cpu_rdata;
      seen_err     = bus.cpu_err;
    end
    if (bus.p_wr) begin
      pwr_cnt++;
      last_pwr_cyc = cyc;
      seen_pwdata  = bus.p_wdata;
      seen_paddr   = bus.p_addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int          a1, pw0, ak0, r;
    bit          prev_keep, keep;
    logic [31:0] addr;

    rst           = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_be    = '0;
    bus.cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);

    check("reset cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("reset cpu_err", 32'(bus.cpu_err), 32'd0);
    check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
    check("reset p_wr", 32'(bus.p_wr), 32'd0);
    check("reset p_addr", bus.p_addr, 32'd0);
    check("reset p_wdata", bus.p_wdata, 32'd0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    rst    = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Full store
    issue(1'b1, 32'h0400_0000, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    check("full store p_wr cycle", 32'(last_pwr_cyc - t0), 32'd1);
    check("full store ack cycle", 32'(last_ack_cyc - t0), 32'd2);
    check("full store p_wdata", seen_pwdata, 32'h1234_5678);
    check("full store p_addr", seen_paddr, 32'd0);
    check("full store err", 32'(seen_err), 32'd0);
    check("full store reg0", env_mem[0], 32'h1234_5678);

    // Load
    issue(1'b1, 32'h0400_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0);
    issue(1'b0, 32'h0400_0004, 4'hF, 32'h0, 1'b0, 1'b0);
    check("load ack cycle", 32'(last_ack_cyc - t0), 32'd2);
    check("load rdata", seen_rdata, 32'hCAFE_F00D);

    // Partial store (RMW)
    issue(1'b1, 32'h0400_0000, 4'hF, 32'hAABB_CCDD, 1'b0, 1'b0);
    issue(1'b1, 32'h0400_0000, 4'b0010, 32'h0000_EE00, 1'b0, 1'b0);
    check("rmw p_wr cycle", 32'(last_pwr_cyc - t0), 32'd2);
    check("rmw ack cycle", 32'(last_ack_cyc - t0), 32'd3);
    check("rmw p_wdata", seen_pwdata, 32'hAABB_EEDD);
    check("rmw reg0", env_mem[0], 32'hAABB_EEDD);

    // Out-of-region store
    pw0 = pwr_cnt;
    issue(1'b1, 32'h0800_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("err store ack cycle", 32'(last_ack_cyc - t0), 32'd1);
    check("err store err flag", 32'(seen_err), 32'(ERR_EXP));
    check("err store no p_wr", 32'(pwr_cnt), 32'(pw0));

    // Back-to-back loads with cpu_req held
    issue(1'b0, 32'h0400_0000, 4'hF, 32'h0, 1'b0, 1'b1);
    a1 = last_ack_cyc;
    issue(1'b0, 32'h0400_0004, 4'hF, 32'h0, 1'b1, 1'b0);
    check("b2b ack spacing", 32'(last_ack_cyc - a1), 32'd3);

    // Reset during RMW_RD
    pw0 = pwr_cnt;
    ak0 = ack_cnt;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 32'h0400_0008;
    bus.cpu_be    = 4'b0001;
    bus.cpu_wdata = 32'h0000_0077;
    @(negedge clk);
    check("abort in RMW_RD", 32'(dbg_state), 32'(ST_RMW_RD));
    rst         = 1'b0;
    bus.cpu_req = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    check("abort cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("abort cpu_err", 32'(bus.cpu_err), 32'd0);
    check("abort cpu_rdata", bus.cpu_rdata, 32'd0);
    check("abort p_wr", 32'(bus.p_wr), 32'd0);
    check("abort p_addr", bus.p_addr, 32'd0);
    check("abort p_wdata", bus.p_wdata, 32'd0);
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    model_reset();
    check("abort no p_wr", 32'(pwr_cnt), 32'(pw0));
    check("abort no ack", 32'(ack_cnt), 32'(ak0));
    issue(1'b0, 32'h0400_0008, 4'hF, 32'h0, 1'b0, 1'b0);
    check("post-reset load", seen_rdata, init_val(2));

    // Randomized traffic
    prev_keep = 1'b0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'h0400_0000 | ($urandom & 32'h00FF_FFFF);
      else             addr = 32'h0400_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      keep = (k != 299) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom, prev_keep, keep);
      prev_keep = keep;
    end

    repeat (3) @(negedge clk);
    check("expectations drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bridge.md
# periph_bridge

Sits between the core's load/store port and the memory-mapped peripheral register block (LED/GPIO registers). Accepts byte-addressed CPU requests with byte enables over a req/ack handshake, decodes the peripheral region and converts to word indices. Drives the peripheral block's single-cycle word-only write port. Performs read-modify-write for partial-word stores, because the peripheral registers accept only full 32-bit writes.

## Interface
- `BASE_ADDR`, default 32'h0400_0000: byte base of the peripheral region; bits [23:0] must be zero.
- `REGION_BITS`, default 24: byte-address width of the region. The word index is `REGION_BITS-2` = 22 bits.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_req` in 1: request valid; held high until `cpu_ack`.
- `cpu_wr` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_be` in 4: byte enables; bit n selects byte lane [8n+7:8n].
- `cpu_wdata` in 32: store data, in lane position.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: load data; valid while `cpu_ack` is high.
- `cpu_err` out 1: error flag; valid while `cpu_ack` is high.
- `p_addr` out 32: word index to the peripherals. Bits [21:0] are `cpu_addr[23:2]`; upper bits are zero.
- `p_wr` out 1: peripheral write strobe, registered.
- `p_wdata` out 32: peripheral write data.
- `p_rdata` in 32: peripheral read data, combinational from `p_addr`.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE with `cpu_req`=1: latch `cpu_wr`, `cpu_addr`, `cpu_be` and `cpu_wdata`; drive `p_addr` from the latched address. Then:
  - error → RESP
  - load → RD
  - store with `cpu_be`=4'hF → WR
  - other store → RMW_RD
- Error condition: `cpu_addr[31:REGION_BITS]` ≠ `BASE_ADDR[31:REGION_BITS]`, or `cpu_be`=0.
- `cpu_addr[1:0]` is ignored; lane selection comes from `cpu_be` only.
- RD: capture `p_rdata` into `cpu_rdata`, then go to RESP. Loads return the full word regardless of `cpu_be`.
- WR: `p_wr`=1 and `p_wdata`=latched wdata for exactly this cycle, then go to RESP.
- RMW_RD: capture `p_rdata` into the merge register, then go to RMW_WR.
- RMW_WR: `p_wr`=1 and `p_wdata`=merge result, then go to RESP.
  - Merge result, per lane: `cpu_be[n]` ? wdata lane : captured lane.
- RESP: `cpu_ack`=1 for one cycle, then go to IDLE. `cpu_rdata` is zero on stores.
- In every state other than IDLE, `cpu_req` and the CPU inputs are not sampled.
- `p_wr` is never high outside WR or RMW_WR.

## Timing
- Reset values: `cpu_ack`=0, `cpu_err`=0, `cpu_rdata`=0, `p_wr`=0, `p_addr`=0, `p_wdata`=0, state IDLE.
- Latency, counting the cycle `cpu_req` is sampled in IDLE as cycle 0, to `cpu_ack` high:
  - load: 2 cycles
  - full store: 2 cycles
  - partial store: 3 cycles
  - error: 1 cycle
- `p_addr` is stable from cycle 1 until the cycle after `cpu_ack`.
- RMW_WR directly follows RMW_RD, so no other writer can intervene.
- Back-to-back requests: after RESP, IDLE samples `cpu_req` on the next cycle, giving a one-cycle bubble. A `cpu_req` that stays high after `cpu_ack` is treated as a new request.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE on that edge.
  - No `cpu_ack` or `p_wr` is issued for the aborted request.
  - A write already strobed is not undone.

## Configuration
- `PERIPH_BRIDGE_ERR_EN` defined:
  - Error-condition requests complete with `cpu_err`=1 after 1 cycle.
  - No peripheral access occurs.
  - `cpu_rdata`=0.
- Macro undefined:
  - `cpu_err` is tied to 0.
  - Error-condition loads complete with `cpu_rdata`=0.
  - Error-condition stores are silently dropped.
  - Timing is unchanged: still 1 cycle, still no `p_wr`.

## Structure
- Package `periph_bridge_pkg` holds the state enum/localparams, the default `BASE_ADDR` and `REGION_BITS`, and a word-index width constant (22) shared with the peripheral block.
- Sub-module `byte_merge`: combinational. Inputs are old word, new word and 4-bit `be`; output is the merged word. It is used in RMW_RD/RMW_WR.

## Test plan
- Full store to 0x0400_0000 with `cpu_wdata`=0x1234_5678 and `be`=F:
  - `p_wr` high for one cycle at cycle 1, with `p_addr`=0 and `p_wdata`=0x1234_5678.
  - `cpu_ack` at cycle 2 with `cpu_err`=0.
- Load from 0x0400_0004 with `p_rdata` returning 0xCAFE_F00D for `p_addr`=1 → `cpu_ack` at cycle 2 with `cpu_rdata`=0xCAFE_F00D.
- Partial store, register 0 = 0xAABB_CCDD, `be`=4'b0010, `cpu_wdata`=0x0000_EE00:
  - `p_wr` high at cycle 2 with `p_wdata`=0xAABB_EEDD.
  - `cpu_ack` at cycle 3.
- Store to 0x0800_0000:
  - With `PERIPH_BRIDGE_ERR_EN`: `cpu_ack` with `cpu_err`=1 at cycle 1, and no `p_wr`.
  - Without it: `cpu_err`=0, and still no `p_wr`.
- Reset driven low during RMW_RD:
  - No `p_wr` and no `cpu_ack` follow.
  - After reset, all outputs are 0 and a fresh load completes normally.
- Two back-to-back loads with `cpu_req` held high → two `cpu_ack` pulses, 3 cycles apart.
